// File: rtl/cell_exerciser.sv
// rtl/cell_exerciser.sv - exhaustive 4-input cell exerciser comparing Y against a truth table
// Optional macro CELL_EXERCISER_GRAY_EN selects Gray-code pattern order instead of binary.
module cell_exerciser #(
    parameter int          SETTLE = 2,
    parameter logic [15:0] TRUTH  = 16'h0777
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        ABORT,
    output logic        A1,
    output logic        A2,
    output logic        B1,
    output logic        B2,
    input  logic        Y,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [4:0]  ERR_COUNT,
    output logic [15:0] FAIL_VEC
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t      state, state_n;
    logic [3:0]  step, step_n;
    logic [3:0]  cnt, cnt_n;
    logic [3:0]  stim, stim_n;
    logic [4:0]  err, err_n;
    logic [15:0] fvec, fvec_n;

    function automatic logic [3:0] pattern_of(input logic [3:0] s);
`ifdef CELL_EXERCISER_GRAY_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            step  <= '0;
            cnt   <= '0;
            stim  <= '0;
            err   <= '0;
            fvec  <= '0;
        end else begin
            state <= state_n;
            step  <= step_n;
            cnt   <= cnt_n;
            stim  <= stim_n;
            err   <= err_n;
            fvec  <= fvec_n;
        end
    end

    always_comb begin
        state_n = state;
        step_n  = step;
        cnt_n   = cnt;
        stim_n  = stim;
        err_n   = err;
        fvec_n  = fvec;
        case (state)
            IDLE, FIN: begin
                if (START && !ABORT) begin
                    state_n = DRIVE;
                    step_n  = '0;
                    cnt_n   = SETTLE_LOAD;
                    stim_n  = pattern_of(4'd0);
                    err_n   = '0;
                    fvec_n  = '0;
                end
            end
            DRIVE: begin
                if (ABORT) begin
                    state_n = IDLE;
                    stim_n  = '0;
                end else if (cnt == 4'd0) begin
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            SAMPLE: begin
                if (ABORT) begin
                    state_n = IDLE;
                    stim_n  = '0;
                end else begin
                    // stim holds the pattern value, which indexes both TRUTH and FAIL_VEC
                    if (Y != TRUTH[stim]) begin
                        err_n        = err + 5'd1;
                        fvec_n[stim] = 1'b1;
                    end
                    if (step == 4'd15) begin
                        state_n = FIN;
                        stim_n  = '0;
                    end else begin
                        state_n = DRIVE;
                        step_n  = step + 4'd1;
                        stim_n  = pattern_of(step + 4'd1);
                        cnt_n   = SETTLE_LOAD;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                stim_n  = '0;
            end
        endcase
    end

    assign A1        = stim[0];
    assign A2        = stim[1];
    assign B1        = stim[2];
    assign B2        = stim[3];
    assign BUSY      = (state == DRIVE) || (state == SAMPLE);
    assign DONE      = (state == FIN);
    assign PASS      = (state == FIN) && (err == 5'd0);
    assign ERR_COUNT = err;
    assign FAIL_VEC  = fvec;

endmodule

// File: tb/tb_cell_exerciser.sv
// tb/tb_cell_exerciser.sv - randomized self-checking bench for cell_exerciser
// Honours CELL_EXERCISER_GRAY_EN for the expected pattern order.
module tb_cell_exerciser;

    localparam int SETTLE = 2;
    localparam int HOLD   = SETTLE + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        a1, a2, b1, b2;
    logic        y;
    logic        busy, done, pass;
    logic [4:0]  err_count;
    logic [15:0] fail_vec;
    logic [15:0] cell_tt = 16'h0;
    logic [15:0] ideal;
    logic [3:0]  stim;

    int n_checks = 0;
    int n_fail   = 0;

    cell_exerciser #(.SETTLE(SETTLE), .TRUTH(16'h0777)) dut (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort),
        .A1(a1), .A2(a2), .B1(b1), .B2(b2), .Y(y),
        .BUSY(busy), .DONE(done), .PASS(pass),
        .ERR_COUNT(err_count), .FAIL_VEC(fail_vec)
    );

    always #5 clk = ~clk;

    assign stim = {b2, b1, a2, a1};
    assign y    = cell_tt[stim];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_pattern(input int s);
`ifdef CELL_EXERCISER_GRAY_EN
        logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                      4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        return gray_tab[s];
`else
        return 4'(s);
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Launch a run; on return we are at the negedge showing values visible at edge k+1.
    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_run(input logic [15:0] tt, input bit pulses, input string tag);
        int done_at, busy_bad, order_bad, ham_bad, exp_e;
        logic [15:0] exp_f;
        logic [3:0]  prev;
        cell_tt = tt;
        launch();
        done_at = 0; busy_bad = 0; order_bad = 0; ham_bad = 0;
        prev = 4'd0;
        for (int j = 1; j <= 80 && done_at == 0; j++) begin
            if (j > 1) @(negedge clk);
            if (done) begin
                done_at = j;
            end else begin
                if (!busy) busy_bad++;
                if ((j - 1) / HOLD < 16 && stim !== exp_pattern((j - 1) / HOLD)) order_bad++;
                if (j > 1 && (j - 1) % HOLD == 0 && $countones(stim ^ prev) != 1) ham_bad++;
                prev = stim;
            end
            start = pulses && (j == 5 || j == 20);
        end
        start = 1'b0;
        exp_f = tt ^ ideal;
        exp_e = $countones(exp_f);
        check({tag, "_done_edge"}, done_at, 16 * HOLD + 1);
        check({tag, "_busy"}, busy_bad, 0);
        check({tag, "_order"}, order_bad, 0);
`ifdef CELL_EXERCISER_GRAY_EN
        check({tag, "_hamming"}, ham_bad, 0);
`endif
        check({tag, "_err"}, err_count, exp_e);
        check({tag, "_fvec"}, fail_vec, exp_f);
        check({tag, "_pass"}, pass, exp_e == 0);
        check({tag, "_stim0"}, stim, 0);
    endtask

    initial begin
        int abort_off, n_done;
        logic [15:0] pf;
        bit saw_done;

        for (int i = 0; i < 16; i++)
            ideal[i] = ~((i[0] & i[1]) | (i[2] & i[3]));

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_fvec", fail_vec, 0);
        check("rst_stim", stim, 0);
        rst = 1'b0;

        do_run(ideal, 1'b0, "ideal");
        do_run(16'hFFFF, 1'b0, "tie1");
        check("tie1_fvec_const", fail_vec, 16'hF888);
        check("tie1_err_const", err_count, 7);
        check("tie1_done", done, 1);
        do_run(~ideal, 1'b0, "allbad");
        check("allbad_err16", err_count, 16);
        do_run(ideal, 1'b1, "startpulse");

        // START with ABORT from FIN: no run begins
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("startabort_busy", busy, 0);

        // abort mid-run with partial results held
        cell_tt = 16'h0000;
        launch();
        abort_off = 11;
        repeat (abort_off - 2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_done = (abort_off - 1) / HOLD;
        pf = 16'h0;
        for (int s = 0; s < n_done; s++)
            pf[exp_pattern(s)] = cell_tt[exp_pattern(s)] ^ ideal[exp_pattern(s)];
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_stim", stim, 0);
        check("abort_err", err_count, $countones(pf));
        check("abort_fvec", fail_vec, pf);
        repeat (5) @(negedge clk);
        check("abort_hold_err", err_count, $countones(pf));
        check("abort_hold_done", done, 0);
        do_run(ideal, 1'b0, "after_abort");

        // reset mid-run while step 7 is driven
        cell_tt = 16'h0000;
        launch();
        repeat (7 * HOLD) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_pass", pass, 0);
        check("midrst_err", err_count, 0);
        check("midrst_fvec", fail_vec, 0);
        check("midrst_stim", stim, 0);
        saw_done = 1'b0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("midrst_quiet", saw_done, 0);

        for (int r = 0; r < 6; r++)
            do_run(16'($urandom), r[0], "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
